// File: rtl/multicycle_datapath_if.sv
// Instruction-fetch and data-memory req/ack bus for multicycle_datapath.
// The core drives req/address/data; the memory side answers with ack and read data.
interface multicycle_datapath_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16
);
    logic              ins_req;
    logic [PC_W-1:0]   ins_addr;
    logic              ins_ack;
    logic [31:0]       ins_data;
    logic              dm_req;
    logic              dm_we;
    logic [DATA_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;

    modport master (
        output ins_req, ins_addr, dm_req, dm_we, dm_addr, dm_wdata,
        input  ins_ack, ins_data, dm_ack, dm_rdata
    );

    modport slave (
        input  ins_req, ins_addr, dm_req, dm_we, dm_addr, dm_wdata,
        output ins_ack, ins_data, dm_ack, dm_rdata
    );
endinterface

// File: rtl/multicycle_datapath.sv
// Non-overlapped multi-cycle processor: FETCH/DECODE/EXEC/MEM/WB controller,
// register file, ALU and PC, with instruction and data memories behind req/ack.
module multicycle_datapath #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16,
    parameter int NREGS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_datapath_if.master bus,
    output logic [3:0]            opcode,
    output logic [PC_W-1:0]       pc,
    output logic                  retire,
    output logic                  halted,
    output logic                  illegal,
    input  logic [3:0]            dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LW   = 4'd6;
    localparam logic [3:0] OP_SW   = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_BNE  = 4'd9;
    localparam logic [3:0] OP_J    = 4'd10;
    localparam logic [3:0] OP_HALT = 4'd15;

    logic [2:0]        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
    logic              illegal_q, illegal_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic              rf_we;
    logic [3:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic [3:0]         op, rs, rt, rd;
    logic signed [15:0] imm_s;
    logic [DATA_W-1:0]  imm_ext;
    logic [PC_W-1:0]    pc_inc, pc_br;

    assign op      = ir_q[31:28];
    assign rs      = ir_q[27:24];
    assign rt      = ir_q[23:20];
    assign rd      = ir_q[19:16];
    assign imm_s   = ir_q[15:0];
    assign imm_ext = DATA_W'(imm_s);
    assign pc_inc  = pc_q + PC_W'(1);
    assign pc_br   = pc_inc + PC_W'(imm_s);

    // Indices at or above NREGS, and r0, always read as zero.
    function automatic logic [DATA_W-1:0] rf_read(input logic [3:0] idx);
        if (idx != 4'd0 && int'(idx) < NREGS) return regs_q[idx];
        return '0;
    endfunction

    // Requests are masked during reset so a memory never sees a transfer the core ignores.
    assign bus.ins_req  = !rst && (state_q == S_FETCH);
    assign bus.ins_addr = pc_q;
    assign bus.dm_req   = !rst && (state_q == S_MEM);
    assign bus.dm_we    = bus.dm_req && (op == OP_SW);
    assign bus.dm_addr  = alu_q;
    assign bus.dm_wdata = b_q;

    assign opcode   = op;
    assign pc       = pc_q;
    assign halted   = (state_q == S_HALT);
    assign illegal  = illegal_q;
    assign dbg_data = rf_read(dbg_addr);

    always_comb begin
        // NOTE: every signal gets a default here so no path through the case infers a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        illegal_d = illegal_q;
        rf_we     = 1'b0;
        rf_waddr  = rd;
        rf_wdata  = alu_q;
        retire    = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (bus.ins_ack) begin
                    ir_d    = bus.ins_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d = rf_read(rs);
                b_d = rf_read(rt);
                if (op inside {[4'd11:4'd14]}) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
                case (op)
                    OP_ADD:  alu_d = a_q + b_q;
                    OP_SUB:  alu_d = a_q - b_q;
                    OP_AND:  alu_d = a_q & b_q;
                    OP_OR:   alu_d = a_q | b_q;
                    OP_SLT:  alu_d = ($signed(a_q) < $signed(b_q)) ? DATA_W'(1) : '0;
                    OP_ADDI: alu_d = a_q + imm_ext;
                    OP_LW, OP_SW: begin
                        alu_d   = a_q + imm_ext;
                        state_d = S_MEM;
                    end
                    OP_BEQ, OP_BNE: begin
                        pc_d    = ((a_q == b_q) == (op == OP_BEQ)) ? pc_br : pc_inc;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_J: begin
                        pc_d    = PC_W'(ir_q[15:0]);
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_HALT: begin
                        retire  = 1'b1;
                        state_d = S_HALT;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                if (bus.dm_ack) begin
                    if (op == OP_SW) begin
                        retire  = 1'b1;
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = bus.dm_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = (op == OP_ADDI || op == OP_LW) ? rt : rd;
                rf_wdata = (op == OP_LW) ? mdr_q : alu_q;
                pc_d     = pc_inc;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (rf_we && rf_waddr != 4'd0 && int'(rf_waddr) < NREGS) regs_d[rf_waddr] = rf_wdata;
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            illegal_q <= 1'b0;
            // NOTE: the register file is cleared on reset because software relies on zeroed registers.
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            illegal_q <= illegal_d;
            regs_q    <= regs_d;
        end
    end

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised multi-cycle successor of the single-cycle 16-bit datapath.
- Integrates the FSM controller, register file, ALU and PC logic. Instruction and data memories sit outside the block, behind req/ack handshake ports, so slow memories can stall the block.
- Keeps the 32-bit instruction format: [31:28] opcode, [27:24] rs, [23:20] rt, [19:16] rd, [15:0] imm.
- Adds BNE, SLT, ADDI, HALT, illegal-opcode detection, a retire pulse and a debug register read port.

Parameters:
DATA_W, 16, register/ALU/data-memory word width; must be >=16.
PC_W, 16, PC and instruction-address width; word-addressed.
NREGS, 16, register count; must be <=16; rs/rt/rd values >=NREGS read 0 and are not written.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
ins_req  out  1  instruction fetch request.
ins_addr  out  PC_W  fetch address (= pc).
ins_ack  in  1  fetch complete; ins_data valid this cycle.
ins_data  in  32  instruction word.
dm_req  out  1  data access request.
dm_we  out  1  1 = store, 0 = load; valid while dm_req is high.
dm_addr  out  DATA_W  data address (ALU result).
dm_wdata  out  DATA_W  store data (rt value).
dm_ack  in  1  data access complete; dm_rdata valid this cycle on loads.
dm_rdata  in  DATA_W  load data.
opcode  out  4  opcode of the latched instruction.
pc  out  PC_W  current PC.
retire  out  1  one-cycle pulse when an instruction completes.
halted  out  1  high in HALT state.
illegal  out  1  sticky; set when an undefined opcode is decoded.
dbg_addr  in  4  debug register index.
dbg_data  out  DATA_W  combinational read of reg[dbg_addr].

Behaviour:
- Reset values:
  - State FETCH; pc=0; IR=0.
  - All registers 0.
  - ins_req, dm_req, dm_we, retire, halted and illegal all 0.
  - opcode=0.
  - Reset dominates every other event, including a mid-handshake reset. An ack arriving after reset while no req is pending is ignored.
- Register 0 reads 0 always; writes to it are discarded.
- Handshake rule: a transfer completes on the rising edge where req && ack. req and address/data stay stable until that edge; req drops the cycle after. ack without req is ignored. Zero-wait memory (ack tied high) gives 1 cycle per access.
- States:
  - FETCH: ins_req=1. On ack, latch IR=ins_data, then go to DECODE.
  - DECODE: read A=reg[rs], B=reg[rt]; imm is sign-extended to DATA_W.
    - Undefined opcode: set illegal and go to HALT.
    - Otherwise go to EXEC.
  - EXEC: compute the result and go to the next state:
    - ALU ops (ADD, SUB, AND, OR, SLT, ADDI): go to WB.
    - LW/SW: go to MEM.
    - BEQ/BNE/J: update pc, pulse retire, go to FETCH.
    - HALT: pulse retire, go to HALT.
  - MEM: dm_req=1. On ack:
    - LW: latch MDR, go to WB.
    - SW: pulse retire, pc=pc+1, go to FETCH.
  - WB: write the register, pc=pc+1, pulse retire, go to FETCH.
  - HALT: terminal; only rst leaves it. ins_req and dm_req stay 0.
- Opcodes:
  - 0 ADD: rd=rs+rt
  - 1 SUB: rd=rs-rt
  - 2 AND: rd=rs&rt
  - 3 OR: rd=rs|rt
  - 4 SLT: rd = signed(rs)<signed(rt) ? 1 : 0
  - 5 ADDI: rt=rs+imm
  - 6 LW: rt=mem[rs+imm]
  - 7 SW: mem[rs+imm]=rt
  - 8 BEQ: if rs==rt, pc=pc+1+imm; else pc=pc+1
  - 9 BNE: same as BEQ with the condition inverted
  - 10 J: pc=imm[PC_W-1:0]
  - 15 HALT: pc is not advanced
  - 11-14: illegal
- Arithmetic wraps modulo 2^DATA_W. PC arithmetic wraps modulo 2^PC_W; pc=2^PC_W-1 followed by a non-branch gives pc=0.
- Cycles with zero-wait memory:
  - ALU ops: 4.
  - LW: 5.
  - SW: 4.
  - Branches, J, HALT: 3.
  - Each memory wait cycle adds 1.
- retire is high for exactly one cycle per instruction, on the final cycle of that instruction.
- Writing to a register and reading it in the next instruction's DECODE returns the new value; no hazards exist because execution is non-overlapped.

Test Plan:
- Zero-wait program `ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; SLT r4,r2,r1; HALT` -> r3=2, r4=1, halted=1, 5 retire pulses, total 19 cycles after reset release.
- `SW r1,4(r0)` then `LW r5,4(r0)`, with dm_ack delayed 3 cycles each -> dm_req held stable across the waits, dm_we=1 then 0, r5=5, each access 3 cycles longer than zero-wait.
- BEQ taken (r1==r1, imm=-1 at pc=7) -> pc=7. BNE not-taken -> pc+1. J imm=0x0020 -> pc=0x20. Each takes 3 cycles.
- Opcode 12 fetched -> illegal=1, halted=1, no register or memory writes. Next: assert rst -> illegal=0, pc=0, FETCH.
- Assert rst mid-MEM with dm_req high and no ack -> dm_req=0 the next cycle, register unchanged. A late dm_ack is ignored. Writes to r0 leave dbg_data(0)=0. 0x7FFF+1 gives 0x8000 (wrap, no flag).
